ras_ckpt: RTL and testbench
===========================

Name: ras_ckpt

Overview:
- Parametrised return address stack (RAS) for the branch predictor front end. It replaces the fixed 8-entry, 31-bit RAS implied by the core types package.
- Circular buffer indexed by a top-of-stack (TOS) pointer plus a saturating occupancy count.
- Supports call push, return pop, and combined push+pop (coroutine replace).
- Exports a checkpoint (index, count) per prediction. Execute restores that checkpoint on a mispredict.

Parameters:
- RAS_ENTRIES, 8, stack depth; power of 2, >= 2.
- RAS_TARGET_WIDTH, 31, stored target width (PC[31:1]).
- LOG_RAS_ENTRIES, $clog2(RAS_ENTRIES), pointer width (derived).

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, synchronous, active-low
- push_valid  input  1  call predicted this cycle
- push_target  input  RAS_TARGET_WIDTH  return address to push
- pop_valid  input  1  return predicted this cycle
- pop_target  output  RAS_TARGET_WIDTH  entry at TOS (combinational, pre-update)
- pop_hit  output  1  count != 0
- ckpt_index  output  LOG_RAS_ENTRIES  current TOS pointer
- ckpt_count  output  LOG_RAS_ENTRIES+1  current occupancy
- restore_valid  input  1  mispredict restore
- restore_index  input  LOG_RAS_ENTRIES  checkpointed TOS pointer
- restore_count  input  LOG_RAS_ENTRIES+1  checkpointed occupancy

Behaviour:
- State: entry array, ptr, count.
- Reset (nRST low at a CLK edge): ptr=0, count=0, all entries=0. Resulting outputs: pop_target=0, pop_hit=0, ckpt_index=0, ckpt_count=0. Reset overrides all inputs, including mid-sequence.
- pop_target, pop_hit, ckpt_* always reflect the current registered state. Zero-latency read. Updates are visible the next cycle.
- Per-cycle priority is restore > (push, pop).
- restore_valid: ptr<=restore_index; count<=restore_count. Entries are not modified. Any push/pop in the same cycle is ignored.
- push only:
  - ptr<=ptr+1 mod RAS_ENTRIES.
  - entry[ptr+1]<=push_target.
  - count<=min(count+1, RAS_ENTRIES).
  - Overflow wraps and overwrites the oldest entry silently.
- pop only:
  - If count!=0: ptr<=ptr-1 mod RAS_ENTRIES; count<=count-1.
  - If count==0 (underflow): ptr and count unchanged. pop_target still drives entry[ptr]; pop_hit=0 tells the consumer to ignore it.
- push and pop together: entry[ptr]<=push_target. ptr is unchanged. count<=max(count,1).
- Neither: hold.
- Pointer arithmetic is modulo via natural LOG_RAS_ENTRIES-bit wrap. count is saturating in [0, RAS_ENTRIES].
- restore_count > RAS_ENTRIES is illegal. Assert in simulation; RTL behaviour for it is undefined.
- The entry array is a flop array with one write port and one read port. Index 0 is written only through wrap or replace.

Decomposition:
- core_types_pkg holds RAS_ENTRIES, LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES), and RAS_TARGET_WIDTH, replacing the existing RAS constants.
- Add typedef ras_ckpt_t {index, count} to the package, for passing checkpoints down the pipe.
- No sub-module; the array and pointer logic are in-module.

Test Plan (RAS_ENTRIES=8, width 31):
1. Reset, then pop_valid=1 -> pop_target=0, pop_hit=0. Next cycle ckpt_index=0, ckpt_count=0.
2. Push 0x1000, then push 0x2000 -> ckpt_index=2, count=2, pop_target=0x2000. Pop -> pop_target=0x2000 that cycle; next cycle pop_target=0x1000, count=1, index=1.
3. Push values 1..9 over 9 cycles -> count=8, index=1, entry[1]=9. Eight pops -> pop_target sequence 9,8,7,6,5,4,3,2, with pop_hit=1 throughout. Then pop_hit=0 and count=0.
4. Push 0xA, 0xB and save ckpt (2,2). Push 0xC, push 0xD, pop, then restore(2,2) -> index=2, count=2, pop_target=0xB.
5. With count=3 and top=0x30, push 0x99 and pop in the same cycle -> index and count unchanged, pop_target=0x99. Restore(5,1) with push in the same cycle -> index=5, count=1, no entry written.
6. After 4 pushes, drive nRST low for one cycle while push_valid=1 -> all outputs 0. Then push 0x7 -> index=1, count=1, pop_target=0x7.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared front-end constants and types for the return address stack.
package core_types_pkg;

  localparam int RAS_ENTRIES      = 8;
  localparam int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES);
  localparam int RAS_TARGET_WIDTH = 31;

  typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;

  // Checkpoint carried down the pipe with each prediction so execute can
  // rewind the stack on a mispredict.
  typedef struct packed {
    logic [LOG_RAS_ENTRIES-1:0] index;
    logic [LOG_RAS_ENTRIES:0]   count;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt.sv
// Parametrised return address stack with checkpoint/restore.
// A circular entry array is addressed by a TOS pointer. A saturating occupancy
// count tracks how many entries are valid. Reads of TOS are zero-latency.
module ras_ckpt #(
  parameter int RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
  parameter int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH,
  parameter int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0] pop_target,
  output logic                        pop_hit,
  output logic [LOG_RAS_ENTRIES-1:0]  ckpt_index,
  output logic [LOG_RAS_ENTRIES:0]    ckpt_count,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_ENTRIES-1:0]  restore_index,
  input  logic [LOG_RAS_ENTRIES:0]    restore_count
);
  import core_types_pkg::*;

  localparam int CNT_W = LOG_RAS_ENTRIES + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_ENTRIES);

  // Pointer wrap relies on the natural pointer width, so depth must be 2^n.
  if (RAS_ENTRIES < 2 || (1 << LOG_RAS_ENTRIES) != RAS_ENTRIES) begin : g_bad_depth
    $error("ras_ckpt: RAS_ENTRIES must be a power of two and >= 2");
  end

  logic [RAS_TARGET_WIDTH-1:0] entries_q [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;

  // Single write port into the entry array.
  logic                        wr_en;
  logic [LOG_RAS_ENTRIES-1:0]  wr_addr;

  // Next-state selection: restore wins over push/pop; push+pop replaces TOS.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    if (restore_valid) begin
      ptr_d   = restore_index;
      count_d = restore_count;
    end else if (push_valid && pop_valid) begin
      // Coroutine-style replace: overwrite TOS in place, pointer unchanged.
      wr_en   = 1'b1;
      wr_addr = ptr_q;
      count_d = (count_q == '0) ? CNT_W'(1) : count_q;
    end else if (push_valid) begin
      // Overflow silently wraps over the oldest entry; count saturates.
      ptr_d   = ptr_q + 1'b1;
      wr_en   = 1'b1;
      wr_addr = ptr_q + 1'b1;
      count_d = (count_q == FULL_CNT) ? FULL_CNT : count_q + 1'b1;
    end else if (pop_valid && (count_q != '0)) begin
      // Underflowing pops leave state untouched; pop_hit flags them.
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry array: cleared on reset, otherwise one write per cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else if (wr_en) begin
      entries_q[wr_addr] <= push_target;
    end
  end

  assign pop_target = entries_q[ptr_q];
  assign pop_hit    = (count_q != '0);
  assign ckpt_index = ptr_q;
  assign ckpt_count = count_q;

  // A checkpoint can never record more entries than the stack holds.
  a_restore_count_legal : assert property (
    @(posedge CLK) disable iff (!nRST) restore_valid |-> (restore_count <= FULL_CNT)
  );

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt: stack-semantics reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_ras_ckpt;
  localparam int N = 8;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        push_valid = 1'b0;
  logic [30:0] push_target = '0;
  logic        pop_valid = 1'b0;
  logic [30:0] pop_target;
  logic        pop_hit;
  logic [2:0]  ckpt_index;
  logic [3:0]  ckpt_count;
  logic        restore_valid = 1'b0;
  logic [2:0]  restore_index = '0;
  logic [3:0]  restore_count = '0;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: plain stack with modular top index.
  logic [30:0] m_mem [N];
  int m_ptr = 0;
  int m_cnt = 0;

  ras_ckpt dut (
    .CLK(CLK), .nRST(nRST),
    .push_valid(push_valid), .push_target(push_target),
    .pop_valid(pop_valid), .pop_target(pop_target), .pop_hit(pop_hit),
    .ckpt_index(ckpt_index), .ckpt_count(ckpt_count),
    .restore_valid(restore_valid), .restore_index(restore_index),
    .restore_count(restore_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!nRST) begin
      m_ptr = 0;
      m_cnt = 0;
      for (int i = 0; i < N; i++) m_mem[i] = '0;
    end else if (restore_valid) begin
      m_ptr = int'(restore_index);
      m_cnt = int'(restore_count);
    end else if (push_valid && pop_valid) begin
      m_mem[m_ptr] = push_target;
      if (m_cnt == 0) m_cnt = 1;
    end else if (push_valid) begin
      m_ptr = (m_ptr + 1) % N;
      m_mem[m_ptr] = push_target;
      if (m_cnt < N) m_cnt = m_cnt + 1;
    end else if (pop_valid && m_cnt != 0) begin
      m_ptr = (m_ptr + N - 1) % N;
      m_cnt = m_cnt - 1;
    end
  endtask

  // One clock of stimulus; returns just after the edge with the model updated.
  task automatic drive(input bit ps, input logic [30:0] pt, input bit pp,
                       input bit rv = 1'b0, input logic [2:0] ri = '0,
                       input logic [3:0] rc = '0, input bit rstn = 1'b1);
    @(negedge CLK);
    push_valid = ps; push_target = pt; pop_valid = pp;
    restore_valid = rv; restore_index = ri; restore_count = rc;
    nRST = rstn;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic expect_state(input string tag, input int idx, input int cnt, input logic [30:0] tgt);
    check({tag, ".index"}, 32'(ckpt_index), 32'(idx));
    check({tag, ".count"}, 32'(ckpt_count), 32'(cnt));
    check({tag, ".target"}, 32'(pop_target), 32'(tgt));
    check({tag, ".hit"}, 32'(pop_hit), 32'(cnt != 0));
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("model.pop_target", 32'(pop_target), 32'(m_mem[m_ptr]));
      check("model.pop_hit", 32'(pop_hit), 32'(m_cnt != 0));
      check("model.ckpt_index", 32'(ckpt_index), 32'(m_ptr));
      check("model.ckpt_count", 32'(ckpt_count), 32'(m_cnt));
    end
  end

  initial begin
    for (int i = 0; i < N; i++) m_mem[i] = '0;

    // 1: reset, underflowing pop
    do_reset();
    do_reset();
    chk_en = 1'b1;
    expect_state("t1.reset", 0, 0, 31'h0);
    drive(1'b0, '0, 1'b1);
    expect_state("t1.underflow", 0, 0, 31'h0);

    // 2: two pushes then a pop
    drive(1'b1, 31'h1000, 1'b0);
    drive(1'b1, 31'h2000, 1'b0);
    expect_state("t2.push2", 2, 2, 31'h2000);
    drive(1'b0, '0, 1'b1);
    expect_state("t2.pop", 1, 1, 31'h1000);

    // 3: overflow wraps, then drain
    do_reset();
    for (int v = 1; v <= 9; v++) drive(1'b1, 31'(v), 1'b0);
    expect_state("t3.full", 1, 8, 31'h9);
    for (int v = 9; v >= 2; v--) begin
      check("t3.pop_seq", 32'(pop_target), 32'(v));
      check("t3.pop_hit", 32'(pop_hit), 32'h1);
      drive(1'b0, '0, 1'b1);
    end
    check("t3.empty_hit", 32'(pop_hit), 32'h0);
    check("t3.empty_count", 32'(ckpt_count), 32'h0);

    // 4: checkpoint and restore
    do_reset();
    drive(1'b1, 31'hA, 1'b0);
    drive(1'b1, 31'hB, 1'b0);
    check("t4.ckpt_index", 32'(ckpt_index), 32'h2);
    check("t4.ckpt_count", 32'(ckpt_count), 32'h2);
    drive(1'b1, 31'hC, 1'b0);
    drive(1'b1, 31'hD, 1'b0);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1, 3'd2, 4'd2);
    expect_state("t4.restore", 2, 2, 31'hB);

    // 5: replace, then restore with a concurrent push that must be ignored
    do_reset();
    drive(1'b1, 31'h10, 1'b0);
    drive(1'b1, 31'h20, 1'b0);
    drive(1'b1, 31'h30, 1'b0);
    expect_state("t5.pre", 3, 3, 31'h30);
    drive(1'b1, 31'h99, 1'b1);
    expect_state("t5.replace", 3, 3, 31'h99);
    drive(1'b1, 31'h55, 1'b0, 1'b1, 3'd5, 4'd1);
    expect_state("t5.restore", 5, 1, 31'h0);
    drive(1'b0, '0, 1'b0, 1'b1, 3'd4, 4'd1);
    expect_state("t5.nowrite", 4, 1, 31'h0);

    // 6: reset mid-sequence overrides a push
    do_reset();
    for (int v = 1; v <= 4; v++) drive(1'b1, 31'(v), 1'b0);
    drive(1'b1, 31'h77, 1'b0, 1'b0, '0, '0, 1'b0);
    expect_state("t6.reset", 0, 0, 31'h0);
    drive(1'b1, 31'h7, 1'b0);
    expect_state("t6.push", 1, 1, 31'h7);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int r;
      bit rv, ps, pp, rn;
      r  = int'($urandom_range(0, 99));
      rn = (r >= 2);
      rv = (r >= 2 && r < 9);
      ps = ($urandom_range(0, 1) == 1);
      pp = ($urandom_range(0, 1) == 1);
      drive(ps, 31'($urandom()), pp, rv, 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 8)), rn);
    end

    drive(1'b0, '0, 1'b0);
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
